act_output_packer: RTL
======================

# act_output_packer

Downstream neighbour of the elementwise activation stage. It takes the 32-bit signed activation stream, requantizes each element to int8 (rounding arithmetic right shift plus saturation), and packs four results into one 32-bit word. It writes each word to the output activation buffer through a valid/ready write port. A start/done command interface sets the element count, destination base address and shift for each tile.

## Interface
Parameters:
- ADDR_W, 10, output buffer word-address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle command pulse; ignored while busy=1
- base_addr  in  ADDR_W  first word address, latched on start
- count  in  16  number of elements in the tile, latched on start
- shift  in  5  requant right-shift amount (0..31), latched on start
- in_valid  in  1  in_data valid
- in_data  in  32  signed activation from the elementwise stage
- in_ready  out  1  packer accepts in_data this cycle
- wr_en  out  1  write request to the output buffer
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  packed word, lane i = bits [8i+7:8i]
- wr_ready  in  1  buffer accepts the write this cycle
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the tile is complete

## Operation
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. Pack register, lane counter and element counter are cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start with count≠0, latch the command and go to RUN. On start with count=0, go to DONE with no write.
- RUN: an element is accepted when in_valid && in_ready. in_ready = (state==RUN) && (!wr_en || wr_ready).
- Requant: t = in_data + (shift==0 ? 0 : 1<<(shift-1)), computed in 33 bits with no wrap. q = t >>> shift, saturated to [-128, 127].
- Accepted element k goes into lane k mod 4 of the pack register.
- Word issue: when lane 3 fills, or the element is the last one (k = count−1), the word moves to wr_data and wr_en asserts. Unused lanes of a final partial word are 0. The pack register then clears.
- The last element moves the FSM to DRAIN. DRAIN waits for wr_en && wr_ready, then goes to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- Write handshake: once wr_en=1, wr_en, wr_addr and wr_data hold stable until wr_ready=1. wr_addr increments by 1 after each accepted write and wraps modulo 2^ADDR_W.
- When a write completes and a new word issues in the same cycle, wr_en stays high with the new address and data.
- in_data is ignored when in_valid=0 or the FSM is not in RUN.
- Reset asserted mid-tile aborts immediately to the reset state. No done pulse is produced and any pending word is dropped.

## Timing
- Element-to-write latency: 1 cycle. wr_en rises the cycle after the accepted element that completes a word.
- Full throughput is 1 element per cycle with wr_ready held high, giving 1 write per 4 cycles.
- busy rises the cycle after start.
- done is asserted the cycle after the final write handshake, or the cycle after start when count=0.
- Minimum tile time with no stalls: count + 2 cycles from start to done.
- A new start is accepted in the cycle after done.

## Test plan
- Basic pack: shift=0, count=4, base=0x10, in 1,2,3,4 -> single write wr_addr=0x10, wr_data=0x04030201, then done pulse.
- Saturation: shift=0, count=4, in 300,−300,−128,127 -> wr_data=0x7F80807F.
- Rounding: shift=2, count=4, in 6,−6,5,−5 -> lanes 2,−1,1,−1, wr_data=0xFF01FF02.
- Partial word and address wrap: ADDR_W=10, base=0x3FF, count=6, shift=0, in 1..6 -> 0x04030201 @0x3FF, then 0x00000605 @0x000, then done.
- Backpressure: hold wr_ready=0 for 3 cycles while wr_en=1 -> wr_addr and wr_data stable, in_ready=0, no element lost or duplicated, and the following word is correct.
- Corner cases:
  - count=0 gives done exactly 1 cycle after start with no wr_en.
  - start while busy is ignored.
  - reset pulled low mid-tile drives all outputs to 0, and no done is issued.

Source files
------------

// File: rtl/act_output_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : act_output_packer
// Purpose  : Requantizes a 32-bit signed activation stream to int8 (rounding
//            arithmetic right shift plus saturation), packs four results per
//            32-bit word and writes the words to the output activation buffer
//            through a valid/ready write port. A start/done command sets the
//            element count, destination base address and shift of each tile.
// Ports    :
//   clk, reset        clock, asynchronous active-low reset
//   start             one-cycle command pulse (ignored unless idle)
//   base_addr/count/shift  tile command, latched on start
//   in_valid/in_data/in_ready  activation input stream
//   wr_en/wr_addr/wr_data/wr_ready  output buffer write port
//   busy              high while the tile is in progress
//   done              one-cycle pulse when the tile is complete
// Revision : 1.0 - initial release
// ============================================================================
module act_output_packer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       count,
  input  logic [4:0]        shift,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Tile context
  logic [4:0]        r_shift;
  logic [15:0]       r_remaining;   // elements still to accept in this tile
  logic [31:0]       r_pack;        // partially filled output word
  logic [1:0]        r_lane;        // next lane to fill
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;

  // Handshake helpers
  logic w_in_ready;
  logic w_accept;
  logic w_last;
  logic w_issue;
  logic w_wr_fire;

  // Requant datapath; 33 bits so the rounding add can never wrap
  logic signed [32:0] w_ext;
  logic signed [32:0] w_rnd;
  logic signed [32:0] w_t;
  logic signed [32:0] w_sh;
  logic        [7:0]  w_q;
  logic        [31:0] w_word;

  // A new element may enter only when the write slot is free or frees now.
  assign w_in_ready = (r_state == S_RUN) && (!r_wr_en || wr_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_last     = (r_remaining == 16'd1);
  assign w_issue    = w_accept && ((r_lane == 2'd3) || w_last);
  assign w_wr_fire  = r_wr_en && wr_ready;

  assign w_ext = {in_data[31], in_data};
  assign w_rnd = (r_shift == 5'd0) ? '0 : (33'sd1 <<< (r_shift - 5'd1));
  assign w_t   = w_ext + w_rnd;
  assign w_sh  = w_t >>> r_shift;

  always_comb begin
    if (w_sh > 33'sd127) begin
      w_q = 8'h7F;
    end else if (w_sh < -33'sd128) begin
      w_q = 8'h80;
    end else begin
      w_q = w_sh[7:0];
    end
  end

  // Lanes above r_lane are always zero in r_pack, so OR-in is sufficient and
  // a final partial word automatically carries zero in its unused lanes.
  assign w_word = r_pack | (32'(w_q) << {r_lane, 3'b000});

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (count == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_accept && w_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_wr_fire) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift     <= '0;
      r_remaining <= '0;
      r_pack      <= '0;
      r_lane      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_shift     <= shift;
        r_remaining <= count;
        r_wr_addr   <= base_addr;
        r_pack      <= '0;
        r_lane      <= '0;
      end

      if (w_wr_fire) begin
        r_wr_en   <= 1'b0;
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
      end

      // An issuing word overrides the wr_en clear above, so a completing
      // write followed by a new word keeps wr_en high without a bubble.
      if (w_accept) begin
        r_remaining <= r_remaining - 16'd1;
        if (w_issue) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= w_word;
          r_pack    <= '0;
          r_lane    <= '0;
        end else begin
          r_pack <= w_word;
          r_lane <= r_lane + 2'd1;
        end
      end
    end
  end

  assign in_ready = w_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule
`default_nettype wire
